wbx_1master_dec: RTL and testbench

Parametrised single-master Wishbone B4 pipelined interconnect with address decode, in-order acknowledge routing, unmapped-address error and watchdog timeout. It sits between the MCU master and `PERIPH_NUM` peripheral slaves. It tracks outstanding requests so that acks and read data return from the slave that owns them. It forbids switching slaves while requests are still in flight.

---
 rtl/wbx_pkg.sv | 18 +
 rtl/wbx_pend_tracker.sv | 79 +++++++
 rtl/wbx_1master_dec.sv | 119 +++++++++++
 tb/tb_wbx_1master_dec.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wbx_pkg.sv
// Shared Wishbone widths and helpers for the single-master decoder.
package wbx_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Owner register width: slave indices 0..n-1 plus an ERR code equal to n.
  function automatic int owner_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Decode index width; a single slave still gets one address bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wbx_pend_tracker.sv
// Outstanding-request bookkeeping: pending count, owning slave, ack watchdog
// and the one-cycle error pulse.
module wbx_pend_tracker #(
  parameter int OW       = 3,
  parameter int MAX_PEND = 4,
  parameter int TIMEOUT  = 255,
  parameter int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cyc_i,
  input  logic          accept_i,
  input  logic          unmapped_i,
  input  logic [OW-1:0] target_i,
  input  logic          ack_i,
  output logic [PW-1:0] pend_o,
  output logic [OW-1:0] owner_o,
  output logic          err_o,
  output logic          tmo_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [PW-1:0] pend_q, pend_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  logic [TW:0]   tmr_inc;
  logic          up, dn;

  assign tmr_inc = {1'b0, tmr_q} + 1'b1;
  // The watchdog fires on the cycle whose increment would reach TIMEOUT, so
  // the err pulse lands TIMEOUT+1 cycles after the last progress.
  assign tmo_o   = cyc_i & (pend_q != '0) & ~ack_i & (tmr_inc == (TW+1)'(TIMEOUT));
  assign up      = accept_i & ~unmapped_i;
  assign dn      = ack_i;

  // Next-state: cyc abort, then watchdog, then normal accept/ack update.
  always_comb begin
    pend_d  = pend_q;
    owner_d = owner_q;
    tmr_d   = tmr_q;
    err_d   = 1'b0;
    if (!cyc_i) begin
      pend_d = '0;
      tmr_d  = '0;
    end else if (tmo_o) begin
      pend_d = '0;
      tmr_d  = '0;
      err_d  = 1'b1;
    end else begin
      if (accept_i) owner_d = target_i;
      err_d = accept_i & unmapped_i;
      if (up && !dn)      pend_d = pend_q + PW'(1);
      else if (!up && dn) pend_d = pend_q - PW'(1);
      tmr_d = ((pend_q != '0) && !ack_i) ? tmr_inc[TW-1:0] : '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      owner_q <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      owner_q <= owner_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  assign pend_o  = pend_q;
  assign owner_o = owner_q;
  assign err_o   = err_q;

endmodule

// File: rtl/wbx_1master_dec.sv
// Single-master Wishbone B4 pipelined decoder: address decode, in-order ack
// routing back from the owning slave, unmapped-address error, ack watchdog.
module wbx_1master_dec import wbx_pkg::*; #(
  parameter int          PERIPH_NUM = 4,
  parameter logic [31:0] BASE       = 32'h3000_0000,
  parameter int          WIN_BITS   = 16,
  parameter int          MAX_PEND   = 4,
  parameter int          TIMEOUT    = 255
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbm_cyc_o,
  input  logic                         wbm_stb_o,
  input  logic                         wbm_we_o,
  input  logic [WB_ADR_W-1:0]          wbm_adr_o,
  input  logic [WB_SEL_W-1:0]          wbm_sel_o,
  input  logic [WB_DAT_W-1:0]          wbm_dat_o,
  output logic [WB_DAT_W-1:0]          wbm_dat_i,
  output logic                         wbm_stall_i,
  output logic                         wbm_ack_i,
  output logic                         wbm_err_i,
  output logic [PERIPH_NUM-1:0]        wbs_cyc_i,
  output logic [PERIPH_NUM-1:0]        wbs_stb_i,
  output logic                         wbs_we_i,
  output logic [WB_ADR_W-1:0]          wbs_adr_i,
  output logic [WB_SEL_W-1:0]          wbs_sel_i,
  output logic [WB_DAT_W-1:0]          wbs_dat_i,
  input  logic [PERIPH_NUM*WB_DAT_W-1:0] wbs_dat_o,
  input  logic [PERIPH_NUM-1:0]        wbs_stall_o,
  input  logic [PERIPH_NUM-1:0]        wbs_ack_o
);

  localparam int            IW      = idx_w(PERIPH_NUM);
  localparam int            OW      = owner_w(PERIPH_NUM);
  localparam int            PW      = $clog2(MAX_PEND + 1);
  localparam logic [OW-1:0] OWN_ERR = OW'(PERIPH_NUM);
  localparam logic [WB_ADR_W-1:0] BASE_PG = BASE >> WIN_BITS;

  logic [WB_ADR_W-1:0] rel;
  logic                hit;
  logic [IW-1:0]       idx;
  logic [OW-1:0]       tgt;
  logic [PW-1:0]       pend, pend_eff;
  logic [OW-1:0]       owner;
  logic                err_q, tmo;
  logic                own_err, req, blocked, accept, ack_fwd;
  logic                sel_stall, own_ack;
  logic [WB_DAT_W-1:0] own_dat;

  // Window decode: page offset from BASE must fall inside the slave range.
  assign rel     = (wbm_adr_o >> WIN_BITS) - BASE_PG;
  assign hit     = rel < WB_ADR_W'(PERIPH_NUM);
  assign idx     = wbm_adr_o[WIN_BITS +: IW];
  assign tgt     = hit ? OW'(idx) : OWN_ERR;
  assign own_err = (owner == OWN_ERR);
  assign req     = wbm_cyc_o & wbm_stb_o;

  // Pick the targeted slave's stall and the owning slave's ack/data.
  always_comb begin
    sel_stall = 1'b0;
    own_ack   = 1'b0;
    own_dat   = '0;
    for (int k = 0; k < PERIPH_NUM; k++) begin
      if (hit && idx == IW'(k)) sel_stall = wbs_stall_o[k];
      if (owner == OW'(k)) begin
        own_ack = wbs_ack_o[k];
        own_dat = wbs_dat_o[k*WB_DAT_W +: WB_DAT_W];
      end
    end
  end

  assign ack_fwd = wbm_cyc_o & ~wb_rst_i & (pend != '0) & ~own_err & own_ack;

  // Blocking looks at the count after this cycle's ack retires, so a full
  // pipe or a slave switch can advance in the same cycle as the freeing ack.
  // A request arriving on the watchdog cycle is stalled rather than lost.
  assign pend_eff = pend - PW'(ack_fwd);
  assign blocked  = (pend_eff == PW'(MAX_PEND))
                  | ((pend_eff != '0) & ((tgt != owner) | own_err))
                  | err_q | tmo;

  assign wbm_stall_i = blocked | (hit & sel_stall);
  assign accept      = req & ~wbm_stall_i;
  assign wbm_ack_i   = ack_fwd;
  assign wbm_err_i   = err_q & wbm_cyc_o & ~wb_rst_i;
  assign wbm_dat_i   = own_err ? '0 : own_dat;

  // Per-slave strobe and cycle fan-out.
  for (genvar g = 0; g < PERIPH_NUM; g++) begin : g_slv
    assign wbs_stb_i[g] = req & hit & (idx == IW'(g)) & ~blocked;
    assign wbs_cyc_i[g] = wbm_cyc_o & ((hit & (idx == IW'(g)))
                                     | ((pend != '0) & (owner == OW'(g))));
  end

  assign wbs_we_i  = wbm_we_o;
  assign wbs_adr_i = wbm_adr_o;
  assign wbs_sel_i = wbm_sel_o;
  assign wbs_dat_i = wbm_dat_o;

  wbx_pend_tracker #(
    .OW       (OW),
    .MAX_PEND (MAX_PEND),
    .TIMEOUT  (TIMEOUT),
    .PW       (PW)
  ) u_trk (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .cyc_i      (wbm_cyc_o),
    .accept_i   (accept),
    .unmapped_i (~hit),
    .target_i   (tgt),
    .ack_i      (ack_fwd),
    .pend_o     (pend),
    .owner_o    (owner),
    .err_o      (err_q),
    .tmo_o      (tmo)
  );

endmodule

// File: tb/tb_wbx_1master_dec.sv
// Directed bench for wbx_1master_dec: a decode vector table on an idle bus,
// then hand-written multi-cycle sequences for pipelining, switching, errors.
module tb_wbx_1master_dec;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [31:0]  adr, wdat;
  logic [3:0]   sel;
  logic [31:0]  rdat;
  logic         stall, ack, err;
  logic [3:0]   s_cyc, s_stb;
  logic         s_we;
  logic [31:0]  s_adr, s_wdat;
  logic [3:0]   s_sel;
  logic [127:0] s_rdat;
  logic [3:0]   s_stall, s_ack;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  wbx_1master_dec #(
    .PERIPH_NUM (4),
    .BASE       (32'h3000_0000),
    .WIN_BITS   (16),
    .MAX_PEND   (4),
    .TIMEOUT    (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_adr_o   (adr),
    .wbm_sel_o   (sel),
    .wbm_dat_o   (wdat),
    .wbm_dat_i   (rdat),
    .wbm_stall_i (stall),
    .wbm_ack_i   (ack),
    .wbm_err_i   (err),
    .wbs_cyc_i   (s_cyc),
    .wbs_stb_i   (s_stb),
    .wbs_we_i    (s_we),
    .wbs_adr_i   (s_adr),
    .wbs_sel_i   (s_sel),
    .wbs_dat_i   (s_wdat),
    .wbs_dat_o   (s_rdat),
    .wbs_stall_o (s_stall),
    .wbs_ack_o   (s_ack)
  );

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [3:0]  sstall;
    logic [3:0]  sack;
    logic [3:0]  e_stb;
    logic [3:0]  e_cyc;
    logic        e_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drop cyc for one cycle so the next sequence starts from an empty pipe.
  task automatic idle;
    cyc = 0; stb = 0; s_ack = 0; s_stall = 0;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h3000_0010, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h3003_FFFC, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h3002_0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'h3004_0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h2FFF_FFFC, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h3001_0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h3001_0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h3000_0000, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'h3001_0000, 4'b1000, 4'b0000, 4'b0010, 4'b0010, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 32'h3002_1234, 4'b1011, 4'b0100, 4'b0100, 4'b0100, 1'b0};

    s_rdat = {32'hA000_0003, 32'hA000_0002, 32'hDEAD_BEEF, 32'hA000_0000};
    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; sel = 4'hF; wdat = 32'h1234_5678;
    s_stall = 0; s_ack = 0;

    // Reset: ack/err held low even with slaves acking.
    tick();
    cyc = 1; s_ack = 4'b1111; #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    tick();
    rst = 0; s_ack = 0; cyc = 0; #1;
    chk("rst_pend", 32'(dut.pend), 0);
    chk("rst_owner", 32'(dut.owner), 0);
    chk("rst_err_after", 32'(err), 0);
    idle();

    // Decode table on an empty pipe.
    for (int i = 0; i < 10; i++) begin
      cyc = vecs[i].cyc; stb = vecs[i].stb; adr = vecs[i].adr;
      s_stall = vecs[i].sstall; s_ack = vecs[i].sack; #1;
      chk($sformatf("v%0d_stb", i),   32'(s_stb),   32'(vecs[i].e_stb));
      chk($sformatf("v%0d_cyc", i),   32'(s_cyc),   32'(vecs[i].e_cyc));
      chk($sformatf("v%0d_stall", i), 32'(stall),   32'(vecs[i].e_stall));
      chk($sformatf("v%0d_ack", i),   32'(ack),     0);
      chk($sformatf("v%0d_adr", i),   s_adr,        vecs[i].adr);
      tick();
      idle();
    end

    // Single read from slave 1, ack two cycles after the request.
    cyc = 1; stb = 1; we = 0; adr = 32'h3001_0004; #1;
    chk("rd_stb", 32'(s_stb), 32'h2);
    chk("rd_stall", 32'(stall), 0);
    tick();
    stb = 0; #1;
    chk("rd_stb_off", 32'(s_stb), 0);
    chk("rd_pend1", 32'(dut.pend), 1);
    chk("rd_noack", 32'(ack), 0);
    tick();
    s_ack = 4'b0010; #1;
    chk("rd_ack", 32'(ack), 1);
    chk("rd_dat", rdat, 32'hDEAD_BEEF);
    tick();
    s_ack = 0; #1;
    chk("rd_pend0", 32'(dut.pend), 0);
    chk("rd_ack_off", 32'(ack), 0);
    idle();

    // Five back-to-back writes to slave 2, acks withheld.
    cyc = 1; stb = 1; we = 1;
    for (int i = 0; i < 4; i++) begin
      adr = 32'h3002_0000 + 32'(i * 4); #1;
      chk($sformatf("wr%0d_stall", i), 32'(stall), 0);
      chk($sformatf("wr%0d_stb", i), 32'(s_stb), 32'h4);
      tick();
    end
    adr = 32'h3002_0010; #1;
    chk("wr4_full_stall", 32'(stall), 1);
    chk("wr4_full_stb", 32'(s_stb), 0);
    chk("wr_pend4", 32'(dut.pend), 4);
    tick();
    s_ack = 4'b0100; #1;
    chk("wr4_ack_stall", 32'(stall), 0);
    chk("wr4_ack", 32'(ack), 1);
    tick();
    stb = 0; s_ack = 0; #1;
    chk("wr_pend_hold", 32'(dut.pend), 4);
    s_ack = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wr_drain%0d", i), 32'(ack), 1);
      tick();
    end
    s_ack = 0; #1;
    chk("wr_pend_drained", 32'(dut.pend), 0);
    idle();

    // Switch from slave 0 to slave 3.
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0000; #1;
    chk("sw_acc0", 32'(stall), 0);
    tick();
    adr = 32'h3003_0000; #1;
    chk("sw_stall", 32'(stall), 1);
    chk("sw_stb_none", 32'(s_stb), 0);
    chk("sw_cyc", 32'(s_cyc), 32'h9);
    tick();
    s_ack = 4'b0001; #1;
    chk("sw_acc_stall", 32'(stall), 0);
    chk("sw_acc_stb", 32'(s_stb), 32'h8);
    chk("sw_ack0", 32'(ack), 1);
    tick();
    stb = 0; s_ack = 0; #1;
    chk("sw_owner", 32'(dut.owner), 3);
    chk("sw_pend", 32'(dut.pend), 1);
    s_ack = 4'b1000; #1;
    chk("sw_ack3", 32'(ack), 1);
    chk("sw_dat3", rdat, 32'hA000_0003);
    tick();
    idle();

    // Unmapped address.
    cyc = 1; stb = 1; adr = 32'h1000_0000; #1;
    chk("um_stall", 32'(stall), 0);
    chk("um_stb", 32'(s_stb), 0);
    chk("um_err_early", 32'(err), 0);
    tick();
    adr = 32'h3000_0000; #1;
    chk("um_err", 32'(err), 1);
    chk("um_block", 32'(stall), 1);
    chk("um_dat0", rdat, 0);
    tick();
    #1;
    chk("um_err_off", 32'(err), 0);
    chk("um_next_ok", 32'(stall), 0);
    tick();
    idle();

    // Watchdog with TIMEOUT=8: slave 2 never acks.
    cyc = 1; stb = 1; adr = 32'h3002_0000; #1;
    chk("to_acc", 32'(s_stb), 32'h4);
    tick();
    stb = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk($sformatf("to_err_c%0d", c), 32'(err), (c == 9) ? 32'd1 : 32'd0);
      if (c == 9) chk("to_pend", 32'(dut.pend), 0);
      tick();
    end
    s_ack = 4'b0100; #1;
    chk("to_stray", 32'(ack), 0);
    idle();

    // Abort with three in flight.
    cyc = 1; stb = 1; adr = 32'h3001_0000;
    tick(); tick(); tick();
    stb = 0; #1;
    chk("ab_pend3", 32'(dut.pend), 3);
    cyc = 0; s_ack = 4'b0010; #1;
    chk("ab_noack_low", 32'(ack), 0);
    tick();
    cyc = 1; #1;
    chk("ab_pend0", 32'(dut.pend), 0);
    chk("ab_noack", 32'(ack), 0);
    idle();

    // Reset mid-burst.
    cyc = 1; stb = 1; adr = 32'h3000_0000;
    tick(); tick();
    stb = 0; rst = 1; s_ack = 4'b0001; #1;
    chk("rb_ack_in_rst", 32'(ack), 0);
    tick();
    rst = 0; #1;
    chk("rb_pend", 32'(dut.pend), 0);
    chk("rb_ack", 32'(ack), 0);
    chk("rb_err", 32'(err), 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
